// File: rtl/leg_cache_pkg.sv
// Shared types and address-field helpers for the LEG instruction cache.
package leg_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH
    } icache_state_t;

    function automatic logic [31:0] addr_word(input logic [31:0] a, input int unsigned blockbits);
        return (a >> 2) & ((32'd1 << blockbits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_set(input logic [31:0] a, input int unsigned setbits,
                                             input int unsigned blockbits);
        return (a >> (blockbits + 2)) & ((32'd1 << setbits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned setbits,
                                             input int unsigned blockbits);
        return a >> (setbits + blockbits + 2);
    endfunction

endpackage

// File: rtl/instr_cache_nway_if.sv
// Fetch-side and bus-side signals of the instruction cache.
interface instr_cache_nway_if;
    logic [31:0] A;
    logic        Invalidate;
    logic [31:0] HRData;
    logic        BusReady;
    logic [31:0] RD;
    logic [31:0] HAddrF;
    logic        HRequestF;
    logic        IStall;

    modport master (
        output A, Invalidate, HRData, BusReady,
        input  RD, HAddrF, HRequestF, IStall
    );

    modport slave (
        input  A, Invalidate, HRData, BusReady,
        output RD, HAddrF, HRequestF, IStall
    );
endinterface

// File: rtl/icache_plru.sv
// Tree pseudo-LRU state per set: heap-ordered node bits 1..WAYS-1, bit=1 steers toward the upper half.
module icache_plru #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned LINES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_en,
    input  logic [$clog2(LINES)-1:0]   upd_set,
    input  logic [$clog2(WAYS)-1:0]    upd_way,
    input  logic                       clr_en,
    input  logic [$clog2(LINES)-1:0]   clr_set,
    input  logic [$clog2(LINES)-1:0]   look_set,
    output logic [$clog2(WAYS)-1:0]    victim
);
    localparam int unsigned WAYBITS = $clog2(WAYS);

    logic [WAYS-1:1]    bits [LINES];
    logic [WAYS-1:1]    upd_bits;
    logic [WAYS-1:1]    look_bits;
    logic [WAYBITS-1:0] upd_node;
    logic [WAYBITS-1:0] look_node;
    logic               dir;

    // The node index drops its MSB on the final shift; only the path bits matter there.
    always_comb begin
        upd_bits = bits[upd_set];
        upd_node = WAYBITS'(1);
        dir      = 1'b0;
        for (int unsigned l = 0; l < WAYBITS; l++) begin
            dir                = upd_way[WAYBITS-1-l];
            upd_bits[upd_node] = ~dir;
            upd_node           = (upd_node << 1) | WAYBITS'(dir);
        end
    end

    always_comb begin
        look_bits = bits[look_set];
        look_node = WAYBITS'(1);
        victim    = '0;
        for (int unsigned l = 0; l < WAYBITS; l++) begin
            victim[WAYBITS-1-l] = look_bits[look_node];
            look_node           = (look_node << 1) | WAYBITS'(look_bits[look_node]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < LINES; s++) begin
                bits[s] <= '0;
            end
        end else begin
            if (upd_en) begin
                bits[upd_set] <= upd_bits;
            end
            if (clr_en) begin
                bits[clr_set] <= '0;
            end
        end
    end

endmodule

// File: rtl/instr_cache_nway.sv
// N-way set-associative instruction cache: combinational hit path, whole-block fill on miss,
// sequential per-set flush on invalidate.
module instr_cache_nway
    import leg_cache_pkg::*;
#(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned LINES     = 4,
    parameter int unsigned BLOCKSIZE = 4
) (
    input logic               clk,
    input logic               reset,
    instr_cache_nway_if.slave bus
);
    localparam int unsigned SETBITS   = $clog2(LINES);
    localparam int unsigned BLOCKBITS = $clog2(BLOCKSIZE);
    localparam int unsigned TAGBITS   = 30 - BLOCKBITS - SETBITS;
    localparam int unsigned WAYBITS   = $clog2(WAYS);

    icache_state_t state, state_next;

    logic [TAGBITS+SETBITS-1:0] fill_line;
    logic [WAYBITS-1:0]         victim;
    logic [BLOCKBITS-1:0]       fill_cnt;
    logic [SETBITS-1:0]         flush_cnt;
    logic                       inv_pending;

    logic [WAYS-1:0]    valid [LINES];
    logic [TAGBITS-1:0] tags  [LINES][WAYS];
    logic [31:0]        data  [LINES][WAYS][BLOCKSIZE];

    logic [TAGBITS-1:0]   a_tag, fill_tag;
    logic [SETBITS-1:0]   a_set, fill_set;
    logic [BLOCKBITS-1:0] a_word;

    logic [WAYS-1:0]    match;
    logic               hit;
    logic [WAYBITS-1:0] hit_way;
    logic [WAYBITS-1:0] plru_victim, miss_victim;
    logic               free_found;

    logic               stall, hreq;
    logic               miss_load, fill_we, fill_done, flush_clr;
    logic               plru_upd;
    logic [SETBITS-1:0] plru_set;
    logic [WAYBITS-1:0] plru_way;

    assign a_tag    = TAGBITS'(addr_tag(bus.A, SETBITS, BLOCKBITS));
    assign a_set    = SETBITS'(addr_set(bus.A, SETBITS, BLOCKBITS));
    assign a_word   = BLOCKBITS'(addr_word(bus.A, BLOCKBITS));
    assign fill_tag = fill_line[TAGBITS+SETBITS-1:SETBITS];
    assign fill_set = fill_line[SETBITS-1:0];

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            match[w] = valid[a_set][w] && (tags[a_set][w] == a_tag);
            if (match[w]) begin
                hit_way = WAYBITS'(w);
            end
        end
    end

    assign hit = |match;

    always_comb begin
        miss_victim = plru_victim;
        free_found  = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!free_found && !valid[a_set][w]) begin
                miss_victim = WAYBITS'(w);
                free_found  = 1'b1;
            end
        end
    end

    icache_plru #(
        .WAYS  (WAYS),
        .LINES (LINES)
    ) u_plru (
        .clk      (clk),
        .reset    (reset),
        .upd_en   (plru_upd),
        .upd_set  (plru_set),
        .upd_way  (plru_way),
        .clr_en   (flush_clr),
        .clr_set  (flush_cnt),
        .look_set (a_set),
        .victim   (plru_victim)
    );

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        hreq       = 1'b0;
        miss_load  = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        flush_clr  = 1'b0;
        plru_upd   = 1'b0;
        plru_set   = a_set;
        plru_way   = hit_way;
        case (state)
            IDLE: begin
                if (bus.Invalidate) begin
                    stall      = 1'b1;
                    state_next = FLUSH;
                end else if (!hit) begin
                    stall      = 1'b1;
                    miss_load  = 1'b1;
                    state_next = FILL;
                end else begin
                    plru_upd = 1'b1;
                end
            end
            FILL: begin
                stall = 1'b1;
                hreq  = 1'b1;
                if (bus.BusReady) begin
                    fill_we = 1'b1;
                    if (fill_cnt == BLOCKBITS'(BLOCKSIZE - 1)) begin
                        fill_done  = 1'b1;
                        plru_upd   = 1'b1;
                        plru_set   = fill_set;
                        plru_way   = victim;
                        state_next = (inv_pending || bus.Invalidate) ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                stall     = 1'b1;
                flush_clr = 1'b1;
                if (flush_cnt == SETBITS'(LINES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending invalidate is cleared on the same edge that enters FLUSH, overriding a late set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fill_line   <= '0;
            victim      <= '0;
            fill_cnt    <= '0;
            flush_cnt   <= '0;
            inv_pending <= 1'b0;
            for (int unsigned s = 0; s < LINES; s++) begin
                valid[s] <= '0;
            end
        end else begin
            state <= state_next;
            if (miss_load) begin
                fill_line                 <= bus.A[31:BLOCKBITS+2];
                victim                    <= miss_victim;
                fill_cnt                  <= '0;
                valid[a_set][miss_victim] <= 1'b0;
            end
            if (fill_we) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (fill_done) begin
                valid[fill_set][victim] <= 1'b1;
            end
            if (state == FILL && bus.Invalidate) begin
                inv_pending <= 1'b1;
            end
            if (state_next == FLUSH && state != FLUSH) begin
                inv_pending <= 1'b0;
                flush_cnt   <= '0;
            end
            if (flush_clr) begin
                valid[flush_cnt] <= '0;
                flush_cnt        <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[fill_set][victim][fill_cnt] <= bus.HRData;
        end
        if (fill_done) begin
            tags[fill_set][victim] <= fill_tag;
        end
    end

    assign bus.IStall    = reset & stall;
    assign bus.HRequestF = reset & hreq;
    assign bus.HAddrF    = reset ? {fill_line, fill_cnt, 2'b00} : '0;
    assign bus.RD        = (reset && hit) ? data[a_set][hit_way][a_word] : '0;

    a_single_hit: assert property (@(posedge clk) disable iff (!reset) $onehot0(match));

endmodule
